// File: rtl/demux_deser.sv
// Serial-to-parallel demux: routes incoming beats into N addressed slots and
// presents the completed frame on a registered parallel bus with valid/ready.
module demux_deser #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned N     = 4,
  localparam int unsigned ADR_W = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [WIDTH-1:0]   in_data,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [ADR_W-1:0]   in_adr,
  input  logic               adr_mode,
  output logic [N*WIDTH-1:0] out_bus,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [N-1:0]       slot_fill
);

  localparam logic [ADR_W-1:0] LastPtr = ADR_W'(N - 1);
  localparam logic [ADR_W:0]   NumSlots = (ADR_W + 1)'(N);

  typedef enum logic [0:0] {StFill, StHold} state_e;

  state_e             state_q, state_d;
  logic [N*WIDTH-1:0] out_bus_q;
  logic [N-1:0]       slot_fill_q;
  logic [ADR_W-1:0]   wr_ptr_q;

  logic               accept;
  logic [ADR_W-1:0]   target;
  logic               target_ok;
  logic [N-1:0]       fill_set;
  logic               frame_done;

  // Datapath decode: target slot and the fill mask after this beat.
  always_comb begin
    accept    = in_valid & in_ready;
    target    = adr_mode ? in_adr : wr_ptr_q;
    // Out-of-range explicit addresses are accepted but write nothing.
    target_ok = {1'b0, target} < NumSlots;
    fill_set  = slot_fill_q;
    for (int unsigned i = 0; i < N; i++) begin
      if (accept && target_ok && (target == i[ADR_W-1:0])) begin
        fill_set[i] = 1'b1;
      end
    end
    frame_done = accept & (&fill_set);
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StFill;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StFill: if (frame_done) state_d = StHold;
      StHold: if (out_ready)  state_d = StFill;
      default: state_d = StFill;
    endcase
  end

  // Output logic
  always_comb begin
    in_ready  = rst_n & (state_q == StFill);
    out_valid = (state_q == StHold);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_bus_q   <= '0;
      slot_fill_q <= '0;
      wr_ptr_q    <= '0;
    end else if (state_q == StHold) begin
      // Slot data survives the handoff; only the fill flags and pointer restart.
      if (out_ready) begin
        slot_fill_q <= '0;
        wr_ptr_q    <= '0;
      end
    end else if (accept) begin
      for (int unsigned i = 0; i < N; i++) begin
        if (target_ok && (target == i[ADR_W-1:0])) begin
          out_bus_q[i*WIDTH +: WIDTH] <= in_data;
        end
      end
      slot_fill_q <= fill_set;
      if (!adr_mode) begin
        wr_ptr_q <= (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + ADR_W'(1);
      end
    end
  end

  assign out_bus   = out_bus_q;
  assign slot_fill = slot_fill_q;

endmodule

// File: tb/tb_demux_deser.sv
// Bench for demux_deser: slot-array model checked every cycle, plus directed
// frames with hand-computed literal expectations.
module tb_demux_deser;

  localparam int W  = 8;
  localparam int NS = 4;
  localparam int AW = 2;

  logic            clk = 1'b0;
  logic            rst_n, in_valid, in_ready, adr_mode, out_valid, out_ready;
  logic [W-1:0]    in_data;
  logic [AW-1:0]   in_adr;
  logic [NS*W-1:0] out_bus;
  logic [NS-1:0]   slot_fill;

  int checks   = 0;
  int failures = 0;

  // Model: slot contents, written flags, auto pointer, frame-pending flag.
  logic [W-1:0]    m_slot [NS];
  bit              m_fill [NS];
  int              m_ptr;
  bit              m_hold;
  logic [NS*W-1:0] dut_frames [$];

  demux_deser #(.WIDTH(W), .N(NS)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_adr   (in_adr),
    .adr_mode (adr_mode),
    .out_bus  (out_bus),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .slot_fill(slot_fill)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [NS*W-1:0] m_bus();
    logic [NS*W-1:0] b;
    for (int i = 0; i < NS; i++) b[i*W +: W] = m_slot[i];
    return b;
  endfunction

  function automatic logic [NS-1:0] m_fillv();
    logic [NS-1:0] f;
    for (int i = 0; i < NS; i++) f[i] = m_fill[i];
    return f;
  endfunction

  function automatic bit m_all_filled();
    for (int i = 0; i < NS; i++) if (!m_fill[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NS; i++) begin
      m_slot[i] = '0;
      m_fill[i] = 1'b0;
    end
    m_ptr  = 0;
    m_hold = 1'b0;
  endtask

  // Advance the model by one rising edge using the inputs currently applied.
  task automatic model_step();
    int tgt;
    if (!rst_n) begin
      model_reset();
    end else if (m_hold) begin
      if (out_ready) begin
        m_hold = 1'b0;
        m_ptr  = 0;
        for (int i = 0; i < NS; i++) m_fill[i] = 1'b0;
      end
    end else if (in_valid) begin
      tgt = adr_mode ? int'(in_adr) : m_ptr;
      if (tgt < NS) begin
        m_slot[tgt] = in_data;
        m_fill[tgt] = 1'b1;
      end
      if (!adr_mode) m_ptr = (m_ptr + 1) % NS;
      if (m_all_filled()) m_hold = 1'b1;
    end
  endtask

  // One cycle: compare at the falling edge, step the model, then drive after the rise.
  task automatic tick();
    @(negedge clk);
    check("in_ready",  64'(in_ready),  64'(rst_n && !m_hold));
    check("out_valid", 64'(out_valid), 64'(m_hold));
    check("out_bus",   64'(out_bus),   64'(m_bus()));
    check("slot_fill", 64'(slot_fill), 64'(m_fillv()));
    if (out_valid && out_ready) dut_frames.push_back(out_bus);
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input bit mode, input logic [AW-1:0] adr, input logic [W-1:0] d);
    in_valid = 1'b1;
    adr_mode = mode;
    in_adr   = adr;
    in_data  = d;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic release_frame();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    int k;
    logic [NS*W-1:0] exp_frame;

    rst_n = 1'b0; in_valid = 1'b0; adr_mode = 1'b0; in_adr = '0;
    in_data = '0; out_ready = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    tick();
    check("rst_in_ready",  64'(in_ready),  64'(0));
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_out_bus",   64'(out_bus),   64'(0));
    check("rst_slot_fill", 64'(slot_fill), 64'(0));
    rst_n = 1'b1;
    tick();

    // Auto-increment frame, then a stalled HOLD with input pressure.
    beat(1'b0, 2'd0, 8'h11);
    beat(1'b0, 2'd0, 8'h22);
    beat(1'b0, 2'd0, 8'h33);
    check("auto_not_yet", 64'(out_valid), 64'(0));
    beat(1'b0, 2'd0, 8'h44);
    check("auto_valid", 64'(out_valid), 64'(1));
    check("auto_bus",   64'(out_bus),   64'h44332211);
    in_valid = 1'b1;
    in_data  = 8'hFF;
    for (int i = 0; i < 5; i++) tick();
    check("hold_in_ready", 64'(in_ready),  64'(0));
    check("hold_bus",      64'(out_bus),   64'h44332211);
    check("hold_fill",     64'(slot_fill), 64'hF);
    release_frame();
    check("rel_valid", 64'(out_valid), 64'(0));
    check("rel_ready", 64'(in_ready),  64'(1));
    check("rel_fill",  64'(slot_fill), 64'(0));
    check("rel_bus",   64'(out_bus),   64'h44332211);

    // Explicit addressing with an overwrite of slot 2.
    beat(1'b1, 2'd2, 8'hAA);
    beat(1'b1, 2'd0, 8'hC0);
    beat(1'b1, 2'd2, 8'hBB);
    check("ovw_fill",  64'(slot_fill), 64'h5);
    check("ovw_valid", 64'(out_valid), 64'(0));
    beat(1'b1, 2'd3, 8'hD3);
    check("exp3_valid", 64'(out_valid), 64'(0));
    beat(1'b1, 2'd1, 8'hE1);
    check("exp_valid", 64'(out_valid), 64'(1));
    check("exp_bus",   64'(out_bus),   64'hD3BBE1C0);
    release_frame();

    // Mixed: explicit beat leaves the auto pointer alone.
    beat(1'b0, 2'd0, 8'h01);
    beat(1'b1, 2'd3, 8'h03);
    beat(1'b0, 2'd0, 8'h02);
    check("mix_not_yet", 64'(out_valid), 64'(0));
    beat(1'b0, 2'd0, 8'h04);
    check("mix_valid", 64'(out_valid), 64'(1));
    check("mix_bus",   64'(out_bus),   64'h03040201);
    release_frame();

    // Reset mid-frame drops the partial frame.
    beat(1'b0, 2'd0, 8'hA1);
    beat(1'b0, 2'd0, 8'hA2);
    beat(1'b0, 2'd0, 8'hA3);
    rst_n = 1'b0;
    tick();
    check("mrst_fill", 64'(slot_fill), 64'(0));
    check("mrst_bus",  64'(out_bus),   64'(0));
    rst_n = 1'b1;
    beat(1'b0, 2'd0, 8'hB1);
    beat(1'b0, 2'd0, 8'hB2);
    beat(1'b0, 2'd0, 8'hB3);
    beat(1'b0, 2'd0, 8'hB4);
    check("mrst_valid", 64'(out_valid), 64'(1));
    check("mrst_frame", 64'(out_bus),   64'hB4B3B2B1);
    release_frame();

    // Back-to-back stream with the consumer always ready.
    dut_frames.delete();
    k         = 0;
    out_ready = 1'b1;
    adr_mode  = 1'b0;
    in_valid  = 1'b1;
    for (int c = 0; c < 25; c++) begin
      bit was_ready;
      in_data   = 8'(32'h40 + k);
      was_ready = in_ready;
      tick();
      if (was_ready) k++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("b2b_beats",  64'(k),                 64'(20));
    check("b2b_frames", 64'(dut_frames.size()), 64'(5));
    for (int f = 0; f < 5; f++) begin
      for (int j = 0; j < NS; j++) exp_frame[j*W +: W] = 8'(32'h40 + 4 * f + j);
      if (f < dut_frames.size()) check("b2b_frame", 64'(dut_frames[f]), 64'(exp_frame));
      else check("b2b_frame_missing", 64'(0), 64'(exp_frame));
    end
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
